// File: rtl/ccm_pkg.sv
// Shared definitions for the CCM counter-mode pipeline.
// Optional build macro CCM_CTR_OVF_ERR_EN adds the ERR state used on counter overflow.
package ccm_pkg;

  localparam int BLOCK_W = 128;

`ifdef CCM_CTR_OVF_ERR_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } ccm_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } ccm_state_e;
`endif

  // Counter block layout is {flag, nonce, counter}, flag in the top bits.
  // Callers pass fields zero-extended to BLOCK_W plus the two lower field widths.
  function automatic logic [BLOCK_W-1:0] ccm_ctr_block(
    input logic [BLOCK_W-1:0] flag,
    input logic [BLOCK_W-1:0] nonce,
    input logic [BLOCK_W-1:0] ctr,
    input int                 nonce_w,
    input int                 count_w
  );
    return (flag << (nonce_w + count_w)) | (nonce << count_w) | ctr;
  endfunction

endpackage

// File: rtl/ccm_ctr_ks_slice.sv
// Keystream block register and MSB-first beat selector.
// The selected slice is the keystream segment that XORs with the current beat.
module ccm_ctr_ks_slice
  import ccm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] ks_i,
  input  logic [IDX_W-1:0]   beat_idx_i,
  output logic [WIDTH-1:0]   slice_o
);

  logic [BLOCK_W-1:0] ks_q;
  logic [BLOCK_W-1:0] ks_shift;

  // Capture one encrypted counter block per AES response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ks_q <= '0;
    end else if (load_i) begin
      ks_q <= ks_i;
    end
  end

  // Beat k takes bits [127-k*WIDTH -: WIDTH]; shifting left brings it to the top
  always_comb begin
    ks_shift = ks_q << (int'(beat_idx_i) * WIDTH);
    slice_o  = ks_shift[BLOCK_W-1 -: WIDTH];
  end

endmodule

// File: rtl/ccm_ctr_pipe.sv
// CCM counter-mode keystream pipeline: issues counter blocks to an external AES
// core, then XORs the returned keystream onto the message beat by beat.
// Optional build macro CCM_CTR_OVF_ERR_EN: counter overflow enters a sticky ERR
// state instead of wrapping silently.
module ccm_ctr_pipe
  import ccm_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          WIDTH_FLAG  = 8,
  parameter int          WIDTH_NONCE = 104,
  parameter int          WIDTH_COUNT = 16,
  parameter int unsigned CTR_INIT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
  input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  output logic [BLOCK_W-1:0]     aes_req_data,
  output logic                   aes_req_valid,
  input  logic                   aes_req_ready,
  input  logic [BLOCK_W-1:0]     aes_rsp_data,
  input  logic                   aes_rsp_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err
);

  localparam int NBEATS = BLOCK_W / WIDTH;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [WIDTH_COUNT-1:0] CTR_RST  = WIDTH_COUNT'(CTR_INIT);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NBEATS - 1);

  ccm_state_e             state_q, state_d;
  logic [WIDTH_COUNT-1:0] ctr_q, ctr_d;
  logic [IDX_W-1:0]       beat_q, beat_d;
  logic [WIDTH_NONCE-1:0] nonce_q;
  logic [WIDTH_FLAG-1:0]  flag_q;
  logic [WIDTH-1:0]       out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [WIDTH-1:0]       ks_slice;
  logic                   id_latch;
  logic                   ks_load;
  logic                   accept;
`ifdef CCM_CTR_OVF_ERR_EN
  logic                   err_q, err_d;
`endif

  ccm_ctr_ks_slice #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_ks (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (ks_load),
    .ks_i       (aes_rsp_data),
    .beat_idx_i (beat_q),
    .slice_o    (ks_slice)
  );

  // Next-state, handshake and counter control
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    beat_d        = beat_q;
    id_latch      = 1'b0;
    ks_load       = 1'b0;
    aes_req_valid = 1'b0;
    in_ready      = 1'b0;
    accept        = 1'b0;
`ifdef CCM_CTR_OVF_ERR_EN
    err_d         = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_REQ;
          ctr_d    = CTR_RST;
          beat_d   = '0;
          id_latch = 1'b1;
        end
      end
      ST_REQ: begin
        aes_req_valid = 1'b1;
        if (aes_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (aes_rsp_valid) begin
          ks_load = 1'b1;
          beat_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (in_last) begin
            // A short final block simply stops; no padding beats are produced
            state_d = ST_IDLE;
            beat_d  = '0;
          end else if (beat_q == LAST_IDX) begin
            beat_d = '0;
`ifdef CCM_CTR_OVF_ERR_EN
            if (ctr_q == '1) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              ctr_d   = ctr_q + WIDTH_COUNT'(1);
              state_d = ST_REQ;
            end
`else
            ctr_d   = ctr_q + WIDTH_COUNT'(1);
            state_d = ST_REQ;
`endif
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end
`ifdef CCM_CTR_OVF_ERR_EN
      ST_ERR: begin
        if (start) begin
          state_d  = ST_REQ;
          ctr_d    = CTR_RST;
          beat_d   = '0;
          id_latch = 1'b1;
          err_d    = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctr_q   <= CTR_RST;
      beat_q  <= '0;
`ifdef CCM_CTR_OVF_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      beat_q  <= beat_d;
`ifdef CCM_CTR_OVF_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Nonce and flag are captured once per message on start
  always_ff @(posedge clk) begin
    if (reset) begin
      nonce_q <= '0;
      flag_q  <= '0;
    end else if (id_latch) begin
      nonce_q <= ccm_ctr_nonce;
      flag_q  <= ccm_ctr_flag;
    end
  end

  // Output beat register; holds its contents while the sink stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_data_q  <= in_data ^ ks_slice;
      out_valid_q <= 1'b1;
      out_last_q  <= in_last;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign aes_req_data = ccm_ctr_block(BLOCK_W'(flag_q), BLOCK_W'(nonce_q), BLOCK_W'(ctr_q),
                                      WIDTH_NONCE, WIDTH_COUNT);
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != ST_IDLE) || out_valid_q;
`ifdef CCM_CTR_OVF_ERR_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ccm_ctr_pipe.sv
// Directed bench for ccm_ctr_pipe: three instances (8-bit, 32-bit, 32-bit with
// counter starting at 0xFFFF) share stimulus; sel picks which one is driven.
// Expectations for the overflow case follow CCM_CTR_OVF_ERR_EN.
module tb_ccm_ctr_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [103:0] nonce;
  logic [7:0]   flag;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic         aes_req_ready;
  logic [127:0] aes_rsp_data;
  logic         aes_rsp_valid;
  int           sel;
  int           aes_lat;

  // per-instance wiring
  logic         st0, st1, st2, iv0, iv1, iv2;
  logic         inr0, inr1, inr2, arqv0, arqv1, arqv2;
  logic [127:0] arqd0, arqd1, arqd2;
  logic [7:0]   od0;
  logic [31:0]  od1, od2;
  logic         ov0, ov1, ov2, ol0, ol1, ol2, bz0, bz1, bz2, er0, er1, er2;

  // observed (selected) instance
  logic         obs_inr, obs_arqv, obs_ov, obs_ol, obs_bz, obs_er;
  logic [127:0] obs_arqd;
  logic [31:0]  obs_od;

  // AES model and injection
  logic         model_v = 1'b0;
  logic [127:0] model_d = '0;
  logic         inj_v = 1'b0;
  logic [127:0] inj_d = '0;

  logic [127:0] req_blk [$];
  logic [31:0]  q_d [$];
  logic         q_l [$];

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [7:0] EXP8 [16] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
  localparam logic [31:0] EXP26 [10] = '{32'hA4A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A40002,
                                         32'hA4A50004, 32'hA5A50005, 32'hA5A50006, 32'hA5A40005,
                                         32'hA4A50008, 32'hA5A50009};
  localparam logic [31:0] EXP4 [4] = '{32'h10110000, 32'h11110001, 32'h11110002, 32'h11100002};
  localparam logic [31:0] EXPOVF [8] = '{32'h01000000, 32'h00000000, 32'h00000000, 32'h0001FFFF,
                                         32'h01000000, 32'h00000000, 32'h00000000, 32'h00010000};

  always #5 clk = ~clk;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  assign obs_inr  = (sel == 0) ? inr0  : (sel == 1) ? inr1  : inr2;
  assign obs_arqv = (sel == 0) ? arqv0 : (sel == 1) ? arqv1 : arqv2;
  assign obs_arqd = (sel == 0) ? arqd0 : (sel == 1) ? arqd1 : arqd2;
  assign obs_ov   = (sel == 0) ? ov0   : (sel == 1) ? ov1   : ov2;
  assign obs_ol   = (sel == 0) ? ol0   : (sel == 1) ? ol1   : ol2;
  assign obs_bz   = (sel == 0) ? bz0   : (sel == 1) ? bz1   : bz2;
  assign obs_er   = (sel == 0) ? er0   : (sel == 1) ? er1   : er2;
  assign obs_od   = (sel == 0) ? {24'h0, od0} : (sel == 1) ? od1 : od2;

  assign aes_rsp_valid = model_v || inj_v;
  assign aes_rsp_data  = inj_v ? inj_d : model_d;

  ccm_ctr_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .start(st0), .ccm_ctr_nonce(nonce), .ccm_ctr_flag(flag),
    .in_data(in_data[7:0]), .in_valid(iv0), .in_ready(inr0), .in_last(in_last),
    .aes_req_data(arqd0), .aes_req_valid(arqv0), .aes_req_ready(aes_req_ready),
    .aes_rsp_data(aes_rsp_data), .aes_rsp_valid(aes_rsp_valid),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_last(ol0),
    .busy(bz0), .err(er0));

  ccm_ctr_pipe #(.WIDTH(32)) u_w32 (
    .clk(clk), .reset(reset), .start(st1), .ccm_ctr_nonce(nonce), .ccm_ctr_flag(flag),
    .in_data(in_data), .in_valid(iv1), .in_ready(inr1), .in_last(in_last),
    .aes_req_data(arqd1), .aes_req_valid(arqv1), .aes_req_ready(aes_req_ready),
    .aes_rsp_data(aes_rsp_data), .aes_rsp_valid(aes_rsp_valid),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1),
    .busy(bz1), .err(er1));

  ccm_ctr_pipe #(.WIDTH(32), .CTR_INIT(32'h0000FFFF)) u_ovf (
    .clk(clk), .reset(reset), .start(st2), .ccm_ctr_nonce(nonce), .ccm_ctr_flag(flag),
    .in_data(in_data), .in_valid(iv2), .in_ready(inr2), .in_last(in_last),
    .aes_req_data(arqd2), .aes_req_valid(arqv2), .aes_req_ready(aes_req_ready),
    .aes_rsp_data(aes_rsp_data), .aes_rsp_valid(aes_rsp_valid),
    .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .out_last(ol2),
    .busy(bz2), .err(er2));

  // Identity AES: log each accepted request, answer with the same block after aes_lat cycles
  always @(negedge clk) begin
    if (obs_arqv && aes_req_ready && !reset) begin
      req_blk.push_back(obs_arqd);
      model_d = obs_arqd;
      @(posedge clk);
      repeat (aes_lat) @(posedge clk);
      #1 model_v = 1'b1;
      @(posedge clk);
      #1 model_v = 1'b0;
    end
  end

  // Record every output beat transferred at the coming rising edge
  always @(negedge clk) begin
    if (obs_ov && out_ready && !reset) begin
      q_d.push_back(obs_od);
      q_l.push_back(obs_ol);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    for (int t = 0; t < 60 && !done; t++) begin
      if (obs_inr) done = 1'b1;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int want);
    for (int t = 0; t < 100 && q_d.size() < want; t++) cyc(1);
    if (q_d.size() < want) chk("out_timeout", q_d.size(), want);
  endtask

  task automatic wait_req(input int want);
    for (int t = 0; t < 100 && req_blk.size() < want; t++) cyc(1);
    if (req_blk.size() < want) chk("req_timeout", req_blk.size(), want);
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_arqv"}, obs_arqv, 0);
    chk({pfx, "_inr"},  obs_inr,  0);
    chk({pfx, "_busy"}, obs_bz,   0);
    chk({pfx, "_ov"},   obs_ov,   0);
    chk({pfx, "_ol"},   obs_ol,   0);
    chk({pfx, "_od"},   obs_od,   0);
    chk({pfx, "_err"},  obs_er,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb;
    int rb;
    reset = 1'b1; start = 1'b0; nonce = 104'h1; flag = 8'h01;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; aes_req_ready = 1'b1; sel = 1; aes_lat = 0;
    cyc(3);
    // reset state of all instances
    chk("rst_busy_w8", bz0, 0);   chk("rst_arqv_w8", arqv0, 0);  chk("rst_inr_w8", inr0, 0);
    chk("rst_busy_ovf", bz2, 0);  chk("rst_arqv_ovf", arqv2, 0); chk("rst_err_ovf", er2, 0);
    chk_quiet("rst_w32");
    reset = 1'b0;
    cyc(2);

    // 8-bit beats, zero plaintext: output equals the counter block bytes
    sel = 0; qb = q_d.size(); rb = req_blk.size();
    do_start();
    for (int i = 0; i < 16; i++) send_beat(32'h0, i == 15);
    wait_out(qb + 16);
    for (int i = 0; i < 16; i++) chk($sformatf("w8_beat%0d", i), q_d[qb+i], {24'h0, EXP8[i]});
    chk("w8_last15", q_l[qb+15], 1);
    chk("w8_last0", q_l[qb], 0);
    chk("w8_nreq", req_blk.size() - rb, 1);
    chk("w8_blk", req_blk[rb], {8'h01, 104'h1, 16'h0001});
    cyc(3);
    chk("w8_idle", obs_bz, 0);

    // 32-bit beats, 10-beat message across three counter blocks
    sel = 1; qb = q_d.size(); rb = req_blk.size();
    do_start();
    for (int i = 0; i < 10; i++) send_beat(32'hA5A50000 + 32'(i), i == 9);
    wait_out(qb + 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("w32_beat%0d", i), q_d[qb+i], EXP26[i]);
      chk($sformatf("w32_last%0d", i), q_l[qb+i], i == 9);
    end
    chk("w32_nreq", req_blk.size() - rb, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("w32_ctr%0d", i), req_blk[rb+i][15:0], i + 1);
    cyc(3);

    // Output stall mid-block: input blocked, output held, nothing lost or repeated
    qb = q_d.size(); rb = req_blk.size();
    do_start();
    send_beat(32'h11110000, 1'b0);
    send_beat(32'h11110001, 1'b0);
    out_ready = 1'b0;
    in_data = 32'h11110002; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk($sformatf("stall_inr%0d", c), obs_inr, 0);
      chk($sformatf("stall_ov%0d", c), obs_ov, 1);
      chk($sformatf("stall_od%0d", c), obs_od, EXP4[1]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send_beat(32'h11110002, 1'b0);
    send_beat(32'h11110003, 1'b1);
    wait_out(qb + 4);
    cyc(4);
    chk("stall_count", q_d.size() - qb, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("stall_beat%0d", i), q_d[qb+i], EXP4[i]);

    // start and a stray AES response during RUN are ignored
    qb = q_d.size(); rb = req_blk.size();
    do_start();
    send_beat(32'h11110000, 1'b0);
    start = 1'b1; nonce = 104'hFF; inj_d = '1; inj_v = 1'b1;
    cyc(1);
    start = 1'b0; nonce = 104'h1; inj_v = 1'b0;
    chk("run_start_arqv", obs_arqv, 0);
    for (int i = 1; i < 4; i++) send_beat(32'h11110000 + 32'(i), i == 3);
    wait_out(qb + 4);
    for (int i = 0; i < 4; i++) chk($sformatf("run_ign_beat%0d", i), q_d[qb+i], EXP4[i]);
    chk("run_ign_nreq", req_blk.size() - rb, 1);
    cyc(3);

    // Reset while waiting on AES
    rb = req_blk.size();
    aes_lat = 8;
    do_start();
    wait_req(rb + 1);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk_quiet("rst_wait");
    reset = 1'b0;
    cyc(12);
    chk("rst_wait_late_rsp", obs_bz, 0);
    aes_lat = 0;

    // Reset while an output beat is pending
    do_start();
    out_ready = 1'b0;
    send_beat(32'h12345678, 1'b0);
    chk("rst_run_pre_ov", obs_ov, 1);
    reset = 1'b1;
    cyc(1);
    chk_quiet("rst_run");
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(2);

    // Clean message after reset
    qb = q_d.size(); rb = req_blk.size();
    do_start();
    for (int i = 0; i < 4; i++) send_beat(32'h11110000 + 32'(i), i == 3);
    wait_out(qb + 4);
    for (int i = 0; i < 4; i++) chk($sformatf("post_rst_beat%0d", i), q_d[qb+i], EXP4[i]);
    chk("post_rst_ctr", req_blk[rb][15:0], 16'h0001);
    cyc(3);

    // Counter overflow starting from 0xFFFF
    sel = 2; qb = q_d.size(); rb = req_blk.size();
    do_start();
`ifdef CCM_CTR_OVF_ERR_EN
    for (int i = 0; i < 4; i++) send_beat(32'h0, 1'b0);
    cyc(3);
    chk("ovf_err", obs_er, 1);
    chk("ovf_nreq", req_blk.size() - rb, 1);
    chk("ovf_ctr0", req_blk[rb][15:0], 16'hFFFF);
    chk("ovf_inr", obs_inr, 0);
    chk("ovf_busy", obs_bz, 1);
    chk("ovf_nout", q_d.size() - qb, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_beat%0d", i), q_d[qb+i], EXPOVF[i]);
    do_start();
    chk("ovf_err_clr", obs_er, 0);
    wait_req(rb + 2);
    chk("ovf_restart_ctr", req_blk[rb+1][15:0], 16'hFFFF);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
`else
    for (int i = 0; i < 8; i++) send_beat(32'h0, i == 7);
    wait_out(qb + 8);
    for (int i = 0; i < 8; i++) chk($sformatf("wrap_beat%0d", i), q_d[qb+i], EXPOVF[i]);
    chk("wrap_nreq", req_blk.size() - rb, 2);
    chk("wrap_ctr0", req_blk[rb][15:0], 16'hFFFF);
    chk("wrap_ctr1", req_blk[rb+1][15:0], 16'h0000);
    chk("wrap_flagnonce", req_blk[rb+1][127:16], {8'h01, 104'h1});
    chk("wrap_err", obs_er, 0);
`endif
    cyc(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ccm_ctr_pipe.md
CCM_CTR_PIPE -- requirements
Module: ccm_ctr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data beat width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL have parameter WIDTH_FLAG, default 8, meaning flag field width.
REQ-003 SHALL have parameter WIDTH_NONCE, default 104, meaning nonce field width.
REQ-004 SHALL have parameter WIDTH_COUNT, default 16, meaning counter field width; WIDTH_FLAG+WIDTH_NONCE+WIDTH_COUNT SHALL equal 128.
REQ-005 SHALL have parameter CTR_INIT, default 1, meaning counter value of the first block after start.
REQ-006 Ports: one clock; reset is synchronous and active-high.
  - clk  in  1  clock, all logic on rising edge
  - reset  in  1  synchronous active-high reset
  - start  in  1  pulse; latches nonce/flag, loads counter to CTR_INIT
  - ccm_ctr_nonce  in  WIDTH_NONCE  nonce
  - ccm_ctr_flag  in  WIDTH_FLAG  flag byte(s)
  - in_data  in  WIDTH  plaintext/ciphertext beat
  - in_valid / in_ready  in / out  1  input handshake
  - in_last  in  1  final beat of message, qualified by in_valid
  - aes_req_data  out  128  counter block {flag, nonce, counter}
  - aes_req_valid / aes_req_ready  out / in  1  AES request handshake
  - aes_rsp_data  in  128  encrypted counter block (keystream)
  - aes_rsp_valid  in  1  keystream valid, single-cycle, no backpressure
  - out_data  out  WIDTH  XORed beat
  - out_valid / out_ready  out / in  1  output handshake
  - out_last  out  1  final output beat
  - busy  out  1  message in progress
  - err  out  1  counter overflow flag

Function
REQ-007 FSM states IDLE, REQ, WAIT, RUN (ERR with REQ-021); start in IDLE -> REQ; start outside IDLE SHALL be ignored.
REQ-008 REQ: aes_req_valid=1, aes_req_data={flag_r, nonce_r, ctr}; on aes_req_ready -> WAIT.
REQ-009 WAIT: on aes_rsp_valid capture aes_rsp_data into keystream register, beat index=0 -> RUN.
REQ-010 RUN: in_ready = !out_valid | out_ready; beat accepted when in_valid & in_ready.
REQ-011 Accepted beat k SHALL produce out_data = in_data ^ ks[127-k*WIDTH -: WIDTH] (MSB-first), out_valid the next cycle, out_last = in_last.
REQ-012 out_valid/out_data/out_last SHALL hold stable while out_valid & !out_ready.
REQ-013 Beat index wraps at 128/WIDTH; on accepting beat 128/WIDTH-1 without in_last: ctr<=ctr+1 -> REQ.
REQ-014 Accepting a beat with in_last -> IDLE at any beat index; partial block SHALL emit only received beats (no zero-padding output).
REQ-015 in_ready SHALL be 0 in IDLE, REQ, WAIT, ERR.
REQ-016 Counter arithmetic modulo 2^WIDTH_COUNT; flag and nonce fields never modified by increment.
REQ-017 busy = (state != IDLE) | out_valid.
REQ-018 Latency: in accept -> out_valid 1 cycle; block boundary stall >= 2 cycles plus AES latency.
REQ-019 aes_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-020 reset SHALL force IDLE, ctr=CTR_INIT, beat index 0, nonce_r/flag_r/keystream 0, out_data 0, and out_valid, out_last, aes_req_valid, in_ready, busy, err all 0; reset mid-message discards pending output.

Configuration
REQ-021 With CCM_CTR_OVF_ERR_EN defined: increment from 2^WIDTH_COUNT-1 SHALL instead enter ERR, set err=1 sticky; ERR exits only on reset or start (start -> REQ, err cleared).
REQ-022 Without CCM_CTR_OVF_ERR_EN: counter wraps to 0 silently, ERR state absent, err tied 0.

Structure
REQ-023 Shared package ccm_pkg SHALL hold BLOCK_W=128, FSM state enum type, and counter-block concatenation function.
REQ-024 One sub-module ccm_ctr_ks_slice (keystream register plus beat-index mux) is natural; remainder flat.

Verification
REQ-025 WIDTH=8, start, nonce=0x00..01, flag=0x01; 16 beats 0x00; AES model = identity -> out beats equal counter block bytes, last byte 0x01; one AES request.
REQ-026 WIDTH=32, 40-byte message (10 beats) -> 3 AES requests, ctr 1,2,3; 10 output beats; out_last on beat 10 only.
REQ-027 out_ready held 0 for 5 cycles mid-block -> in_ready 0, out_data stable, no beat lost or duplicated.
REQ-028 CTR_INIT=0xFFFF, 2-block message: with CCM_CTR_OVF_ERR_EN err=1 after block 1, no second request; without, second request counter=0x0000.
REQ-029 reset asserted in WAIT and in RUN with out_valid=1 -> next cycle all outputs 0, state IDLE; new start runs clean.
REQ-030 start pulsed during RUN -> ignored; aes_rsp_valid pulsed in RUN -> keystream unchanged.
